// File: rtl/xmodem_tx.sv
// XMODEM checksum-mode sender: frames 128-byte blocks from a sync-read memory
// onto a UART tx pin, handling ACK/NAK/timeout retransmission, EOT and CAN abort.
module xmodem_tx #(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned MAX_RETRIES    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  num_blocks,
  output logic [14:0] mem_addr,
  input  logic [7:0]  mem_data,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] EOT = 8'h04;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam logic [7:0] CAN = 8'h18;

  typedef enum logic [3:0] {
    S_IDLE, S_SOH, S_BLK, S_NBLK, S_DATA, S_SUM, S_WAIT_RESP, S_EOT, S_WAIT_EOT, S_CAN
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        shift_q, shift_d;
  logic [3:0]        bit_q, bit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [14:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        blk_q, blk_d;
  logic [7:0]        nblk_q, nblk_d;
  logic [6:0]        idx_q, idx_d;
  logic [7:0]        sum_q, sum_d;
  logic [RTY_W-1:0]  retry_q, retry_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic       load;
  logic [7:0] load_byte;
  logic [7:0] blk_num;
  logic       sending, bit_end, byte_end;
  logic       is_ack, is_nak, tmo, retry_max;

  assign blk_num   = 8'(blk_q + 8'd1);
  assign sending   = (state_q != S_IDLE) && (state_q != S_WAIT_RESP) && (state_q != S_WAIT_EOT);
  assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_end  = bit_end && (bit_q == 4'd9);
  assign is_ack    = rx_valid && (rx_data == ACK);
  assign is_nak    = rx_valid && (rx_data == NAK);
  assign tmo       = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign retry_max = (retry_q == RTY_W'(MAX_RETRIES));

  // Next-state: bit timing, byte sequencing and response handling.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    mem_addr_d = mem_addr_q;
    blk_d      = blk_q;
    nblk_d     = nblk_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    load       = 1'b0;
    load_byte  = 8'h00;

    if (sending) begin
      if (bit_end) begin
        cnt_d   = '0;
        bit_d   = 4'(bit_q + 4'd1);
        tx_d    = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
      end else begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          error_d = 1'b0;
          retry_d = '0;
          nblk_d  = num_blocks;
          blk_d   = 8'd0;
          load    = 1'b1;
          if (num_blocks == 8'd0) begin
            state_d   = S_EOT;
            load_byte = EOT;
          end else begin
            state_d    = S_SOH;
            load_byte  = SOH;
            sum_d      = 8'd0;
            mem_addr_d = 15'd0;
          end
        end
      end
      S_SOH: if (byte_end) begin
        state_d   = S_BLK;
        load      = 1'b1;
        load_byte = blk_num;
      end
      S_BLK: if (byte_end) begin
        state_d   = S_NBLK;
        load      = 1'b1;
        load_byte = ~blk_num;
      end
      S_NBLK: if (byte_end) begin
        state_d    = S_DATA;
        load       = 1'b1;
        load_byte  = mem_data;
        sum_d      = 8'(sum_q + mem_data);
        idx_d      = 7'd0;
        mem_addr_d = {blk_q, 7'd1};
      end
      S_DATA: if (byte_end) begin
        load = 1'b1;
        if (idx_q == 7'd127) begin
          state_d   = S_SUM;
          load_byte = sum_q;
        end else begin
          // Address already points one byte ahead, so mem_data is this next byte.
          load_byte  = mem_data;
          sum_d      = 8'(sum_q + mem_data);
          idx_d      = 7'(idx_q + 7'd1);
          mem_addr_d = {blk_q, 7'(idx_q + 7'd2)};
        end
      end
      S_SUM, S_EOT: if (byte_end) begin
        state_d = (state_q == S_SUM) ? S_WAIT_RESP : S_WAIT_EOT;
        timer_d = '0;
        bit_d   = 4'd0;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
      S_CAN: if (byte_end) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        error_d = 1'b1;
        bit_d   = 4'd0;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
      S_WAIT_RESP: begin
        timer_d = TMR_W'(timer_q + 1'b1);
        if (is_ack) begin
          retry_d = '0;
          load    = 1'b1;
          if (blk_num == nblk_q) begin
            state_d   = S_EOT;
            load_byte = EOT;
          end else begin
            state_d    = S_SOH;
            load_byte  = SOH;
            blk_d      = blk_num;
            sum_d      = 8'd0;
            mem_addr_d = {blk_num, 7'd0};
          end
        end else if (is_nak || tmo) begin
          load = 1'b1;
          if (retry_max) begin
            state_d   = S_CAN;
            load_byte = CAN;
          end else begin
            retry_d    = RTY_W'(retry_q + 1'b1);
            state_d    = S_SOH;
            load_byte  = SOH;
            sum_d      = 8'd0;
            mem_addr_d = {blk_q, 7'd0};
          end
        end
      end
      S_WAIT_EOT: begin
        timer_d = TMR_W'(timer_q + 1'b1);
        if (is_ack) begin
          retry_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (is_nak || tmo) begin
          load = 1'b1;
          if (retry_max) begin
            state_d   = S_CAN;
            load_byte = CAN;
          end else begin
            retry_d   = RTY_W'(retry_q + 1'b1);
            state_d   = S_EOT;
            load_byte = EOT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A newly loaded byte starts its start bit on the same edge.
    if (load) begin
      shift_d = {1'b1, load_byte};
      bit_d   = 4'd0;
      cnt_d   = '0;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= 9'h1FF;
      bit_q      <= 4'd0;
      cnt_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mem_addr_q <= 15'd0;
      blk_q      <= 8'd0;
      nblk_q     <= 8'd0;
      idx_q      <= 7'd0;
      sum_q      <= 8'd0;
      retry_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      mem_addr_q <= mem_addr_d;
      blk_q      <= blk_d;
      nblk_q     <= nblk_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: doc/xmodem_tx.md
# xmodem_tx

Sending end of the XMODEM link used by the board's UART console. On `start` it reads `num_blocks` 128-byte blocks from a synchronous-read memory and serialises each block as an XMODEM checksum packet on the `tx` pin. It consumes ACK/NAK bytes delivered by the existing UART receiver and retransmits on NAK or timeout. After the last block it sends EOT. It is the counterpart of the receiver that accepts SOH/blk/~blk/128 data/checksum frames.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200 baud).
- `TIMEOUT_CYCLES`, 50_000_000, cycles to wait for a response before treating it as a NAK.
- `MAX_RETRIES`, 10, retransmissions allowed per packet before aborting.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a transfer; ignored while `busy`.
- `num_blocks`  in  8  number of blocks to send, sampled when `start` is accepted; 0 means send EOT only.
- `mem_addr`  out  15  memory read address `{block_idx[7:0], byte_idx[6:0]}`.
- `mem_data`  in  8  read data, valid exactly 1 cycle after `mem_addr`.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  single-cycle strobe qualifying `rx_data`.
- `tx`  out  1  serial output; idles high.
- `busy`  out  1  transfer in progress.
- `done`  out  1  1-cycle pulse when EOT is ACKed.
- `error`  out  1  set on abort; sticky until the next accepted `start` or `rst`.

## Operation
- Constants: SOH=0x01, EOT=0x04, ACK=0x06, NAK=0x15, CAN=0x18.
- States:
  - IDLE → SOH → BLK → NBLK → DATA(×128) → SUM → WAIT_RESP.
  - WAIT_RESP on ACK: go to the next block, or to EOT after the last block.
  - WAIT_RESP on NAK or timeout: go to SOH for the same block with `retry`+1.
  - EOT → WAIT_EOT on ACK: DONE; on NAK or timeout: resend EOT with `retry`+1.
  - From either wait state, `retry` == MAX_RETRIES plus a NAK or timeout leads to CAN, then ABORT.
- Block number byte: `(block_idx+1) mod 256`. Second byte is its bitwise complement.
- Checksum: 8-bit sum mod 256 of the 128 data bytes as sent. It is cleared when SOH is emitted and recomputed on every retransmission.
- `retry` clears on each ACK and on `start`.
- Byte framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts `CLKS_PER_BIT` cycles. Consecutive bytes within a packet are back-to-back, so the next start bit immediately follows the stop bit.
- Memory reads are prefetched during the preceding byte's frame. Data bytes are never delayed by read latency.
- `rx_valid` is ignored outside WAIT_RESP/WAIT_EOT. In the wait states, any byte other than ACK/NAK is discarded and does not restart the timeout.
- The timeout counter starts at the end of the stop bit of the SUM/EOT byte.
- DONE: pulse `done`, return to IDLE. ABORT: set `error`, return to IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, `done`=0, `error`=0, `mem_addr`=0, state IDLE, all counters 0.
- `rst` mid-frame: `tx` is 1 from the next edge and the transfer is abandoned. No CAN is sent.
- Start latency: with `start` sampled high at edge k, `busy`=1 and `tx`=0 (SOH start bit) from edge k+1.
- Each byte occupies exactly 10×`CLKS_PER_BIT` cycles.
- Response handling: an ACK/NAK sampled at edge m causes the next transmitted start bit at edge m+1.
- End of transfer: `done` is high for one cycle at edge m+1 after the EOT ACK. `busy` falls at that same edge.
- Abort: `error` and `busy`=0 take effect on the edge that ends the CAN stop bit.
- Packet length: 132 bytes = 1320×`CLKS_PER_BIT` cycles.

## Test plan
- Reset: assert `rst` 5 cycles → `tx`=1, `busy`=0, `done`=0, `error`=0, `mem_addr`=0. Then `rst` mid-byte → `tx`=1 the next cycle and `busy`=0.
- Single block: `num_blocks`=1, `mem_data`=low 7 address bits. Required bytes: 01 01 FE 00..7F C0, each bit 434 cycles. Then inject ACK → bytes 04; inject ACK → one-cycle `done`.
- NAK retransmit: NAK after block 1 → identical 132 bytes resent, checksum C0 again. ACK → EOT.
- Two blocks: `num_blocks`=2 → second packet 01 02 FD with `mem_addr[14:7]`=1. A stray 0x43 in WAIT_RESP is ignored, and a byte received during transmit is ignored.
- Timeout: `TIMEOUT_CYCLES`=1000, no response → retransmission start bit exactly 1000 cycles after the checksum stop bit.
- Abort: `MAX_RETRIES`=2, always NAK → 3 packet transmissions, then 18 (CAN), `error`=1, `busy`=0. A subsequent `start` clears `error`.
